// File: rtl/mem_access_unit_pkg.sv
// Shared CPU definitions: memory-access FSM state encoding, access-size
// encoding and the alignment rule used to reject bad requests.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } mau_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // A request is rejected for the reserved size or a misaligned half/word.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addr_lo[0];
      SIZE_W:  bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane selection and sign/zero extension of a fetched RAM word.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then replicate its top bit when sign-extending.
  always_comb begin
    byte_sel = word[7:0];
    half_sel = word[15:0];
    result   = word;
    case (addr)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    if (addr[1]) half_sel = word[31:16];
    case (size)
      SIZE_B:  result = {{24{sign & byte_sel[7]}}, byte_sel};
      SIZE_H:  result = {{16{sign & half_sel[15]}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a request/response handshake and a single-port
// word RAM. Sub-word stores are done as read-modify-write.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 10
)
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        state
);

  mau_state_e        cur, nxt;
  logic              accept;
  logic              req_err;
  logic              unused_addr_hi;
  logic [ADDR_W+1:0] addr_p1;
  logic [31:0]       wdata_p1;
  logic [1:0]        size_p1;
  logic              sign_p1;
  logic              we_p1;
  logic              err_p1;
  logic [31:0]       word_p2;
  logic [31:0]       load_res;

  // Byte/half store: replace the addressed lane, keep the rest of the word.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    case (size)
      SIZE_B: begin
        case (lane)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      SIZE_H: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign req_err        = is_misaligned(req_size, req_addr[1:0]);
  assign accept         = (cur == ST_IDLE) && req_valid;

  // Request latch (p1) at acceptance; RAM word capture (p2) in WAIT.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      cur      <= ST_IDLE;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      size_p1  <= '0;
      sign_p1  <= 1'b0;
      we_p1    <= 1'b0;
      err_p1   <= 1'b0;
      word_p2  <= '0;
    end else begin
      cur <= nxt;
      if (accept) begin
        addr_p1  <= req_addr[ADDR_W+1:0];
        wdata_p1 <= req_wdata;
        size_p1  <= req_size;
        sign_p1  <= req_sign;
        we_p1    <= req_we;
        err_p1   <= req_err;
      end
      if (cur == ST_WAIT) word_p2 <= mem_rdata;
    end
  end

  // Next-state and handshake/RAM strobes decoded from the current state.
  always_comb begin
    nxt        = cur;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    case (cur)
      ST_IDLE: begin
        req_ready = Reset;
        if (req_valid) begin
          if (req_err)                          nxt = ST_RESP;
          else if (req_we && req_size == SIZE_W) nxt = ST_WRITE;
          else                                  nxt = ST_READ;
        end
      end
      ST_READ: begin
        mem_en = 1'b1;
        nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        nxt = we_p1 ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        nxt    = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  load_align u_load_align (
    .word   (word_p2),
    .addr   (addr_p1[1:0]),
    .size   (size_p1),
    .sign   (sign_p1),
    .result (load_res)
  );

  // Response fields derive from registers frozen during RESP, so they hold.
  assign resp_rdata = (cur == ST_RESP && !we_p1 && !err_p1) ? load_res : '0;
  assign resp_err   = (cur == ST_RESP) && err_p1;
  assign mem_addr   = addr_p1[ADDR_W+1:2];
  assign mem_wdata  = merge_store(word_p2, wdata_p1, size_p1, addr_p1[1:0]);
  assign state      = cur;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table with a response
// scoreboard, plus hand-written backpressure and mid-operation reset cases.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int ADDR_W = 10;

  logic              CLK = 1'b0;
  logic              Reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [1:0]        req_size = '0;
  logic              req_sign = 1'b0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic [2:0]        state;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .req_sign   (req_sign),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .state      (state)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port RAM with one-cycle read latency.
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  logic        init_ram = 1'b0;
  always @(posedge CLK) begin
    if (init_ram) begin
      ram[0] <= 32'h8765_4321;
      ram[1] <= 32'h1122_3344;
      ram[2] <= 32'hCAFE_F00D;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Running totals of RAM strobe cycles.
  int en_cnt = 0;
  int we_cnt = 0;
  always @(negedge CLK) begin
    if (mem_en) en_cnt = en_cnt + 1;
    if (mem_we) we_cnt = we_cnt + 1;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_en;
    int          exp_we;
    int          chk_word;
    logic [31:0] exp_word;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[16];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic sign, input string name);
    check({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_sign  = sign;
    req_valid = 1'b1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      lat++;
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int   e0, w0, lat;
    bit   ok;
    exp_t e;
    e0 = en_cnt;
    w0 = we_cnt;
    sbq.push_back('{v.exp_rdata, v.exp_err, v.exp_lat});
    issue(v.we, v.addr, v.wdata, v.size, v.sign, name);
    wait_resp(lat, ok);
    e = sbq.pop_front();
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: no resp_valid, expected within %0d cycles", name, e.lat);
      return;
    end
    check({name, " rdata"},   resp_rdata,          e.rdata);
    check({name, " err"},     {31'd0, resp_err},   {31'd0, e.err});
    check({name, " latency"}, lat,                 e.lat);
    check({name, " en_cyc"},  en_cnt - e0,         v.exp_en);
    check({name, " we_cyc"},  we_cnt - w0,         v.exp_we);
    @(posedge CLK);
    @(negedge CLK);
    check({name, " idle"}, {29'd0, state}, 32'd0);
    if (v.chk_word >= 0) check({name, " ram"}, ram[v.chk_word], v.exp_word);
  endtask

  initial begin
    int   lat;
    bit   ok;
    int   w0;
    exp_t e;

    //          we    addr          wdata         size    sg    rdata         err  lat en we word exp_word
    vecs[0]  = '{1'b0, 32'h0000_0003, 32'h0,        SIZE_B, 1'b1, 32'hFFFF_FF87, 1'b0, 3, 1, 0, -1, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0002, 32'h0,        SIZE_H, 1'b0, 32'h0000_8765, 1'b0, 3, 1, 0, -1, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0,        SIZE_W, 1'b0, 32'h8765_4321, 1'b0, 3, 1, 0, -1, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0,        SIZE_B, 1'b1, 32'h0000_0021, 1'b0, 3, 1, 0, -1, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0002, 32'h0,        SIZE_H, 1'b1, 32'hFFFF_8765, 1'b0, 3, 1, 0, -1, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0001, 32'h0,        SIZE_B, 1'b0, 32'h0000_0043, 1'b0, 3, 1, 0, -1, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0001, 32'h0,        SIZE_H, 1'b0, 32'h0,         1'b1, 1, 0, 0, -1, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0002, 32'h0,        SIZE_W, 1'b0, 32'h0,         1'b1, 1, 0, 0, -1, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,        2'b11,  1'b0, 32'h0,         1'b1, 1, 0, 0, -1, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0001, 32'h0000_00AB, SIZE_B, 1'b0, 32'h0,        1'b0, 4, 2, 1, 0, 32'h8765_AB21};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,        SIZE_W, 1'b0, 32'h8765_AB21, 1'b0, 3, 1, 0, -1, 32'h0};
    vecs[11] = '{1'b1, 32'h0000_0006, 32'h0000_BEEF, SIZE_H, 1'b0, 32'h0,        1'b0, 4, 2, 1, 1, 32'hBEEF_3344};
    vecs[12] = '{1'b0, 32'h0000_0006, 32'h0,        SIZE_H, 1'b1, 32'hFFFF_BEEF, 1'b0, 3, 1, 0, -1, 32'h0};
    vecs[13] = '{1'b1, 32'h0000_0004, 32'hDEAD_DEAD, 2'b11, 1'b0, 32'h0,         1'b1, 1, 0, 0, 1, 32'hBEEF_3344};
    vecs[14] = '{1'b1, 32'h0000_1004, 32'hA5A5_0F0F, SIZE_W, 1'b0, 32'h0,        1'b0, 2, 1, 1, 1, 32'hA5A5_0F0F};
    vecs[15] = '{1'b0, 32'h0000_2005, 32'h0,        SIZE_B, 1'b1, 32'h0000_000F, 1'b0, 3, 1, 0, -1, 32'h0};

    init_ram = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    init_ram = 1'b0;
    check("rst state",      {29'd0, state},      32'd0);
    check("rst req_ready",  {31'd0, req_ready},  32'd0);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst resp_rdata", resp_rdata,          32'd0);
    check("rst resp_err",   {31'd0, resp_err},   32'd0);
    check("rst mem_en",     {31'd0, mem_en},     32'd0);
    Reset = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Word store held in RESP by backpressure while a new request waits.
    resp_ready = 1'b0;
    sbq.push_back('{32'h0, 1'b0, 2});
    issue(1'b1, 32'h4, 32'h1234_5678, SIZE_W, 1'b0, "bp");
    wait_resp(lat, ok);
    e = sbq.pop_front();
    check("bp got resp", {31'd0, ok}, 32'd1);
    check("bp latency", lat, e.lat);
    req_we = 1'b0; req_addr = 32'h0; req_size = SIZE_W; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp hold%0d valid", k), {31'd0, resp_valid}, 32'd1);
      check($sformatf("bp hold%0d ready", k), {31'd0, req_ready},  32'd0);
      check($sformatf("bp hold%0d rdata", k), resp_rdata,          e.rdata);
      check($sformatf("bp hold%0d err", k),   {31'd0, resp_err},   {31'd0, e.err});
      @(negedge CLK);
    end
    resp_ready = 1'b1;
    @(negedge CLK);
    check("bp no same-cycle accept", {29'd0, state}, 32'd0);
    req_valid = 1'b0;
    check("bp ram", ram[1], 32'h1234_5678);
    @(negedge CLK);

    // Reset asserted while a sub-word store is in READ.
    w0 = we_cnt;
    issue(1'b1, 32'h8, 32'h0000_0055, SIZE_B, 1'b0, "rstrmw");
    @(negedge CLK);
    check("rstrmw in READ", {29'd0, state}, 32'd1);
    Reset = 1'b0;
    @(negedge CLK);
    check("rstrmw state",      {29'd0, state},      32'd0);
    check("rstrmw mem_en",     {31'd0, mem_en},     32'd0);
    check("rstrmw mem_we",     {31'd0, mem_we},     32'd0);
    check("rstrmw resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rstrmw req_ready",  {31'd0, req_ready},  32'd0);
    Reset = 1'b1;
    repeat (3) @(negedge CLK);
    check("rstrmw ram",   ram[2],       32'hCAFE_F00D);
    check("rstrmw no we", we_cnt - w0,  32'd0);
    check("rstrmw idle",  {29'd0, state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 10, word-address width of the attached data RAM.
REQ-002 SHALL have port: CLK  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: Reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: req_valid in 1; req_ready out 1; req_we in 1 (1=store); req_addr in 32 byte address; req_wdata in 32; req_size in 2 (00 byte, 01 half, 10 word, 11 reserved); req_sign in 1 (1=sign-extend loads).
REQ-005 SHALL have ports: resp_valid out 1; resp_ready in 1; resp_rdata out 32; resp_err out 1.
REQ-006 SHALL have ports: mem_en out 1; mem_we out 1; mem_addr out ADDR_W word address; mem_wdata out 32; mem_rdata in 32, valid the cycle after an mem_en=1, mem_we=0 cycle.
REQ-007 SHALL have port: state out 3 current FSM state, for debug.

Function
REQ-008 SHALL implement FSM states IDLE=0, READ=1, WAIT=2, WRITE=3, RESP=4.
REQ-009 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 in IDLE, latching addr, wdata, size, sign, we.
REQ-010 Accepted request SHALL be errored (go directly to RESP, resp_err=1, resp_rdata=0, no mem_en) when size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
REQ-011 Load transitions: IDLE->READ->WAIT->RESP; resp_valid first asserted 3 cycles after acceptance.
REQ-012 Word store transitions: IDLE->WRITE->RESP; resp_valid asserted 2 cycles after acceptance.
REQ-013 Byte/half store (read-modify-write): IDLE->READ->WAIT->WRITE->RESP; resp_valid asserted 4 cycles after acceptance.
REQ-014 mem_en SHALL be 1 exactly in READ and WRITE; mem_we SHALL be 1 exactly in WRITE; mem_addr = latched addr[ADDR_W+1:2] whenever mem_en=1; upper address bits ignored.
REQ-015 In WAIT, mem_rdata SHALL be captured into an internal word register.
REQ-016 Load result: byte = captured word lane addr[1:0] (lane 0 = bits 7:0), half = lane addr[1] (lane 0 = bits 15:0), word = whole; extended to 32 bits by sign-bit replication if req_sign=1, else zero-extended.
REQ-017 Store merge: byte writes wdata[7:0] into lane addr[1:0], half writes wdata[15:0] into lane addr[1], other bits from captured word; word store writes wdata unchanged.
REQ-018 resp_rdata, resp_err SHALL be stable while resp_valid=1; store responses return resp_rdata=0, resp_err=0.
REQ-019 RESP SHALL hold until resp_ready=1, then return to IDLE next edge; a new request SHALL NOT be accepted in the same cycle as the response handshake.
REQ-020 resp_valid and req_ready SHALL never both be 1.

Reset
REQ-021 Reset=0 at a rising edge SHALL force state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0 and clear latched request and captured word, from any state.
REQ-022 Reset mid-operation SHALL abort without issuing a pending WRITE; mem_en=0, mem_we=0 in the cycle after reset is sampled.
REQ-023 While Reset=0, req_ready SHALL be 0.

Structure
REQ-024 State encodings and size encodings (SIZE_B=00, SIZE_H=01, SIZE_W=10) SHALL live in the shared CPU definitions package.
REQ-025 Load lane select/extension SHALL be a combinational sub-module load_align (inputs word, addr[1:0], size, sign; output 32-bit result).

Verification
REQ-026 RAM word 0 = 0x8765_4321; load byte addr 0x3 sign=1 -> resp_rdata 0xFFFF_FF87 at cycle 3 after acceptance, resp_err=0.
REQ-027 Same word; load half addr 0x2 sign=0 -> 0x0000_8765; load word addr 0x0 -> 0x8765_4321.
REQ-028 Store byte 0xAB addr 0x1 into word 0x8765_4321 -> RAM word 0x8765_AB21, resp_valid at cycle 4, exactly one mem_we pulse.
REQ-029 Load half addr 0x1, load word addr 0x2, size=11 -> each resp_err=1, resp_rdata=0, resp_valid at cycle 1, mem_en never asserted.
REQ-030 Word store 0x1234_5678 addr 0x4 with resp_ready held 0 for 5 cycles -> resp_valid held, req_ready=0 throughout; Reset=0 asserted in READ of a sub-word store -> state IDLE next cycle, RAM unchanged.
